// File: rtl/bus_rx_fifo.sv
// Receive FIFO behind a bus-slave write port: first-word-fall-through head, sticky overflow flag,
// registered status word. Define BUS_RX_FIFO_OVF_COUNT_EN to add a saturating 8-bit overflow counter.
module bus_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_stb,
  input  logic [15:0] wr_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_ovf,
  output logic [15:0] status
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [15:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg;
  logic                  ovf_reg, ovf_next;
  logic [15:0]           head_reg;
  logic                  pop, push_ok, ovf_event;
  logic [7:0]            ovf_cnt;
  logic [4:0]            count_field;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    pop         = ~empty_reg & out_ready;
    push_ok     = wr_stb & (~full_reg | pop);
    ovf_event   = wr_stb & full_reg & ~pop;
    wr_ptr_next = push_ok ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push_ok) begin
      count_next = count_reg - CNT_ONE;
    end
    ovf_next = ovf_reg;
    if (clr_ovf) begin
      ovf_next = 1'b0;
    end
    if (ovf_event) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CNT_FULL);
      empty_reg  <= (count_next == CNT_ZERO);
      ovf_reg    <= ovf_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Registered head read; bypass covers the word being written into the slot that becomes head.
  always_ff @(posedge clock) begin
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= wr_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

`ifdef BUS_RX_FIFO_OVF_COUNT_EN
  logic [7:0] ovf_cnt_reg, ovf_cnt_next;

  always_comb begin
    ovf_cnt_next = ovf_cnt_reg;
    if (clr_ovf) begin
      ovf_cnt_next = 8'd0;
    end else if (ovf_event && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_next = ovf_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_cnt_reg <= 8'd0;
    end else begin
      ovf_cnt_reg <= ovf_cnt_next;
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`else
  assign ovf_cnt = 8'd0;
`endif

  assign count_field = 5'(count_reg);
  assign out_valid   = ~empty_reg;
  assign out_data    = head_reg;
  assign status      = {ovf_reg, full_reg, empty_reg, ovf_cnt, count_field};

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed self-checking bench for bus_rx_fifo (DEPTH_LOG2 = 4); expectations follow the macro build.
module tb_bus_rx_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_stb = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] status;

  int errors = 0;
  int checks = 0;

  bus_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clock(clock),
    .reset(reset),
    .wr_stb(wr_stb),
    .wr_data(wr_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_ovf(clr_ovf),
    .status(status)
  );

  always #5 clock = ~clock;

`ifdef BUS_RX_FIFO_OVF_COUNT_EN
  localparam logic [15:0] OVF3_STATUS = 16'hC070;
`else
  localparam logic [15:0] OVF3_STATUS = 16'hC010;
`endif

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 16; i++) begin
      wr_stb  = 1'b1;
      wr_data = base + 16'(i);
      step();
    end
    wr_stb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    if (status !== 16'h2000) begin
      errors++; $display("FAIL reset_status got=%h exp=%h", status, 16'h2000);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    $display("test_reset done status=%h", status);
  endtask

  task automatic test_single_push();
    wr_stb = 1'b1; wr_data = 16'h1234;
    step();
    wr_stb = 1'b0;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out_data !== 16'h1234) begin
      errors++; $display("FAIL single_data got=%h exp=1234", out_data);
    end
    checks++;
    if (status !== 16'h0001) begin
      errors++; $display("FAIL single_status got=%h exp=0001", status);
    end
    checks++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (status !== 16'h2000) begin
      errors++; $display("FAIL single_pop_status got=%h exp=2000", status);
    end
    checks++;
    $display("test_single_push done data=%h", 16'h1234);
  endtask

  task automatic test_fill_drain();
    fill(16'h0000);
    if (status !== 16'h4010) begin
      errors++; $display("FAIL fill_status got=%h exp=4010", status);
    end
    checks++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (out_data !== 16'(i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_word%0d got=%h/%b exp=%h/1", i, out_data, out_valid, 16'(i));
      end
      checks++;
      step();
    end
    out_ready = 1'b0;
    if (status !== 16'h2000) begin
      errors++; $display("FAIL drain_status got=%h exp=2000", status);
    end
    checks++;
    $display("test_fill_drain done status=%h", status);
  endtask

  task automatic test_overflow();
    fill(16'h0100);
    for (int i = 0; i < 3; i++) begin
      wr_stb = 1'b1; wr_data = 16'hDEA0 + 16'(i);
      step();
    end
    wr_stb = 1'b0;
    if (status !== OVF3_STATUS) begin
      errors++; $display("FAIL ovf3_status got=%h exp=%h", status, OVF3_STATUS);
    end
    checks++;
    // clear and a fresh overflow together: flag stays set, counter restarts from 0
    clr_ovf = 1'b1; wr_stb = 1'b1; wr_data = 16'hDEAF;
    step();
    clr_ovf = 1'b0; wr_stb = 1'b0;
    if (status !== 16'hC010) begin
      errors++; $display("FAIL clr_with_ovf_status got=%h exp=C010", status);
    end
    checks++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    if (status !== 16'h4010) begin
      errors++; $display("FAIL clr_status got=%h exp=4010", status);
    end
    checks++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (out_data !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL ovf_drain_word%0d got=%h exp=%h", i, out_data, 16'h0100 + 16'(i));
      end
      checks++;
      step();
    end
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || status !== 16'h2000) begin
      errors++; $display("FAIL ovf_extras_absent got=%b/%h exp=0/2000", out_valid, status);
    end
    checks++;
    $display("test_overflow done status=%h", status);
  endtask

  task automatic test_full_push_pop();
    fill(16'h0200);
    if (out_data !== 16'h0200) begin
      errors++; $display("FAIL fpp_head got=%h exp=0200", out_data);
    end
    checks++;
    wr_stb = 1'b1; wr_data = 16'hBEEF; out_ready = 1'b1;
    step();
    wr_stb = 1'b0; out_ready = 1'b0;
    if (status !== 16'h4010) begin
      errors++; $display("FAIL fpp_status got=%h exp=4010", status);
    end
    checks++;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [15:0] exp_word;
      exp_word = (i == 16) ? 16'hBEEF : 16'h0200 + 16'(i);
      if (out_data !== exp_word) begin
        errors++; $display("FAIL fpp_word%0d got=%h exp=%h", i, out_data, exp_word);
      end
      checks++;
      step();
    end
    out_ready = 1'b0;
    if (status !== 16'h2000) begin
      errors++; $display("FAIL fpp_end_status got=%h exp=2000", status);
    end
    checks++;
    $display("test_full_push_pop done status=%h", status);
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 5; i++) begin
      wr_stb = 1'b1; wr_data = 16'h0300 + 16'(i);
      step();
    end
    if (status !== 16'h0005) begin
      errors++; $display("FAIL rp_pre_status got=%h exp=0005", status);
    end
    checks++;
    reset = 1'b1; wr_stb = 1'b1; wr_data = 16'h0399; out_ready = 1'b1; clr_ovf = 1'b1;
    step();
    reset = 1'b0; wr_stb = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    if (status !== 16'h2000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rp_status got=%h/%b exp=2000/0", status, out_valid);
    end
    checks++;
    wr_stb = 1'b1; wr_data = 16'h55AA;
    step();
    wr_stb = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 16'h55AA || status !== 16'h0001) begin
      errors++; $display("FAIL rp_first_push got=%b/%h/%h exp=1/55aa/0001", out_valid, out_data, status);
    end
    checks++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (status !== 16'h2000) begin
      errors++; $display("FAIL rp_drain_status got=%h exp=2000", status);
    end
    checks++;
    $display("test_reset_priority done status=%h", status);
  endtask

`ifdef BUS_RX_FIFO_OVF_COUNT_EN
  task automatic test_saturate();
    fill(16'h0400);
    wr_stb = 1'b1; wr_data = 16'hFFFF;
    for (int i = 0; i < 255; i++) step();
    if (status !== 16'hDFF0) begin
      errors++; $display("FAIL sat255_status got=%h exp=DFF0", status);
    end
    checks++;
    for (int i = 0; i < 45; i++) step();
    wr_stb = 1'b0;
    if (status !== 16'hDFF0) begin
      errors++; $display("FAIL sat300_status got=%h exp=DFF0", status);
    end
    checks++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    if (status !== 16'h4010) begin
      errors++; $display("FAIL sat_clr_status got=%h exp=4010", status);
    end
    checks++;
    $display("test_saturate done status=%h", status);
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_priority();
`ifdef BUS_RX_FIFO_OVF_COUNT_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
